// File: rtl/uart16550_rx.sv
// 16550-style UART receiver: oversamples sin_i on 16x baud ticks and delivers one
// character per push_o pulse with parity, framing and break status.
module uart16550_rx (
  input  logic       rst_ni,
  input  logic       clk_i,
  input  logic       baudout_i,
  input  logic       sin_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       stick_i,
  output logic       push_o,
  output logic [7:0] d_o,
  output logic       pe_o,
  output logic       fe_o,
  output logic       bi_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t     state_r, state_nxt;
  logic       sync_r, sin_s;
  logic [3:0] cnt_r, cnt_nxt;
  logic [2:0] bitcnt_r, bitcnt_nxt;
  logic [7:0] data_r, data_nxt;
  logic       par_r, par_nxt;
  logic [2:0] bit_idx_s;
  logic       stop_tick_s, par_xor_s, pe_raw_s, pe_s, fe_s, bi_s, busy_nxt;
  logic       push_r, pe_r, fe_r, bi_r, busy_r;
  logic [7:0] d_r;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= 1'b1;
      sin_s  <= 1'b1;
    end else begin
      sync_r <= sin_i;
      sin_s  <= sync_r;
    end
  end

  // State and counter registers; next values only differ from current on baud ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      bitcnt_r <= 3'd0;
      data_r   <= 8'h00;
      par_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      bitcnt_r <= bitcnt_nxt;
      data_r   <= data_nxt;
      par_r    <= par_nxt;
    end
  end

  // Next-state logic; every bit is sampled when the sample counter reaches zero.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bitcnt_nxt  = bitcnt_r;
    data_nxt    = data_r;
    par_nxt     = par_r;
    stop_tick_s = 1'b0;
    bit_idx_s   = (3'd4 + {1'b0, wls_i}) - bitcnt_r;
    if (baudout_i) begin
      case (state_r)
        ST_IDLE: begin
          if (!sin_s) begin
            state_nxt = ST_START;
            cnt_nxt   = 4'd7;
            data_nxt  = 8'h00;
            par_nxt   = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_r == 4'd0) begin
            if (sin_s) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt  = ST_DATA;
              cnt_nxt    = 4'd15;
              bitcnt_nxt = 3'd4 + {1'b0, wls_i};
            end
          end else begin
            cnt_nxt = cnt_r - 4'd1;
          end
        end
        ST_DATA: begin
          if (cnt_r == 4'd0) begin
            data_nxt[bit_idx_s] = sin_s;
            cnt_nxt             = 4'd15;
            if (bitcnt_r == 3'd0) begin
              state_nxt = pen_i ? ST_PARITY : ST_STOP;
            end else begin
              bitcnt_nxt = bitcnt_r - 3'd1;
            end
          end else begin
            cnt_nxt = cnt_r - 4'd1;
          end
        end
        ST_PARITY: begin
          if (cnt_r == 4'd0) begin
            par_nxt   = sin_s;
            state_nxt = ST_STOP;
            cnt_nxt   = 4'd15;
          end else begin
            cnt_nxt = cnt_r - 4'd1;
          end
        end
        ST_STOP: begin
          if (cnt_r == 4'd0) begin
            stop_tick_s = 1'b1;
            state_nxt   = sin_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_nxt = cnt_r - 4'd1;
          end
        end
        ST_BREAK: begin
          if (sin_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_BREAK;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      stop_tick_s = 1'b0;
    end
  end

  // Status decode evaluated at the stop-bit sample tick.
  always_comb begin
    par_xor_s = (^data_r) ^ par_r;
    case ({stick_i, eps_i})
      2'b00:   pe_raw_s = ~par_xor_s;
      2'b01:   pe_raw_s = par_xor_s;
      2'b10:   pe_raw_s = ~par_r;
      2'b11:   pe_raw_s = par_r;
      default: pe_raw_s = 1'b0;
    endcase
    pe_s     = pen_i & pe_raw_s;
    fe_s     = ~sin_s;
    bi_s     = (data_r == 8'h00) & (~pen_i | ~par_r) & ~sin_s;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Registered outputs; character status holds until the next push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_r <= 1'b0;
      d_r    <= 8'h00;
      pe_r   <= 1'b0;
      fe_r   <= 1'b0;
      bi_r   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      push_r <= stop_tick_s;
      busy_r <= busy_nxt;
      if (stop_tick_s) begin
        d_r  <= data_r;
        pe_r <= pe_s;
        fe_r <= fe_s;
        bi_r <= bi_s;
      end
    end
  end

  assign push_o = push_r;
  assign d_o    = d_r;
  assign pe_o   = pe_r;
  assign fe_o   = fe_r;
  assign bi_o   = bi_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_uart16550_rx.sv
// Directed bench for uart16550_rx: frames are driven bit by bit, expected
// characters go through a scoreboard queue and are checked at each push_o.
module tb_uart16550_rx;

  logic       rst_ni, clk_i, baudout_i, sin_i;
  logic [1:0] wls_i;
  logic       pen_i, eps_i, stick_i;
  logic       push_o, pe_o, fe_o, bi_o, busy_o;
  logic [7:0] d_o;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   pushes = 0;
  int   mark;

  uart16550_rx dut (
    .rst_ni   (rst_ni),
    .clk_i    (clk_i),
    .baudout_i(baudout_i),
    .sin_i    (sin_i),
    .wls_i    (wls_i),
    .pen_i    (pen_i),
    .eps_i    (eps_i),
    .stick_i  (stick_i),
    .push_o   (push_o),
    .d_o      (d_o),
    .pe_o     (pe_o),
    .fe_o     (fe_o),
    .bi_o     (bi_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit time is 16 baud ticks; baudout_i is high every cycle.
  task automatic bit_time(input logic v);
    sin_i = v;
    repeat (16) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < nbits; i++) bit_time(d[i]);
    if (par_en) bit_time(par_bit);
    bit_time(stop_bit);
    sin_i = 1'b1;
  endtask

  task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bi = bi;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk_i);
    check(tag, sb.size(), 0);
  endtask

  task automatic config_set(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls_i = w; pen_i = p; eps_i = e; stick_i = s;
  endtask

  // Scoreboard consumer: every push must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (push_o) begin
      pushes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_push: observed d=%0h expected no push", d_o);
      end else begin
        cur = sb.pop_front();
        check("push_d", d_o, cur.d);
        check("push_pe", pe_o, cur.pe);
        check("push_fe", fe_o, cur.fe);
        check("push_bi", bi_o, cur.bi);
      end
    end
  end

  initial begin
    rst_ni = 1'b0; baudout_i = 1'b1; sin_i = 1'b1;
    config_set(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk_i);
    check("rst_push", push_o, 0);
    check("rst_d", d_o, 0);
    check("rst_flags", {pe_o, fe_o, bi_o}, 0);
    check("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // 8N1 0x55
    expect_char(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    drain("drain_8n1");
    repeat (20) @(negedge clk_i);
    check("busy_after_8n1", busy_o, 0);

    // 7E1 0x41 with wrong and correct parity
    config_set(2'd2, 1'b1, 1'b1, 1'b0);
    expect_char(8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    expect_char(8'h41, 1'b0, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    drain("drain_7e1");

    // 8O1 0x55 correct parity, then stick-1 parity sent as 0
    config_set(2'd3, 1'b1, 1'b0, 1'b0);
    expect_char(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b1, 1'b1, 1'b1);
    config_set(2'd3, 1'b1, 1'b0, 1'b1);
    expect_char(8'hC3, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_parity");

    // back-to-back 8N1 frames with no idle gap
    config_set(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk_i);
    expect_char(8'h0F, 1'b0, 1'b0, 1'b0);
    expect_char(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1);
    drain("drain_b2b");

    // 4-tick glitch: false start, no push
    repeat (20) @(negedge clk_i);
    mark = pushes;
    sin_i = 1'b0;
    repeat (4) @(negedge clk_i);
    sin_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("glitch_busy_high", busy_o, 1);
    repeat (30) @(negedge clk_i);
    check("glitch_busy_low", busy_o, 0);
    check("glitch_no_push", pushes, mark);

    // 5N1 break: line low for three frame times
    config_set(2'd0, 1'b0, 1'b0, 1'b0);
    mark = pushes;
    expect_char(8'h00, 1'b0, 1'b1, 1'b1);
    sin_i = 1'b0;
    repeat (3 * 7 * 16) @(negedge clk_i);
    check("break_busy_held", busy_o, 1);
    check("break_one_push", pushes, mark + 1);
    sin_i = 1'b1;
    repeat (30) @(negedge clk_i);
    check("break_busy_low", busy_o, 0);
    check("break_still_one", pushes, mark + 1);
    check("break_d_stable", {d_o, fe_o, bi_o}, {8'h00, 1'b1, 1'b1});
    drain("drain_break");

    // 8N1 framing error without break
    config_set(2'd3, 1'b0, 1'b0, 1'b0);
    mark = pushes;
    expect_char(8'hA3, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk_i);
    drain("drain_fe");
    check("fe_one_push", pushes, mark + 1);
    check("fe_busy_low", busy_o, 0);

    // reset during data bit 3; the partial frame must vanish
    mark = pushes;
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    sin_i = 1'b1;
    repeat (8) @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("midrst_push", push_o, 0);
    check("midrst_d", d_o, 0);
    check("midrst_flags", {pe_o, fe_o, bi_o}, 0);
    check("midrst_busy", busy_o, 0);
    rst_ni = 1'b1;
    repeat (200) @(negedge clk_i);
    check("midrst_no_push", pushes, mark);
    expect_char(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    drain("drain_after_rst");
    repeat (20) @(negedge clk_i);
    check("final_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart16550_rx.md
UART16550_RX -- requirements
Module: uart16550_rx

Interface
REQ-001 rst_ni  input  1  asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock, rising edge.
REQ-003 baudout_i  input  1  single-cycle enable pulse at 16x the baud rate.
REQ-004 sin_i  input  1  serial input, asynchronous to clk_i, idles high.
REQ-005 wls_i  input  2  word length select: 0=5, 1=6, 2=7, 3=8 data bits.
REQ-006 pen_i, eps_i, stick_i  input  1 each  parity enable, even parity select, stick parity.
REQ-007 push_o  output  1  one-clk_i pulse; received character is valid on d_o/pe_o/fe_o/bi_o.
REQ-008 d_o  output  8  received data, LSB received first; unused upper bits are 0.
REQ-009 pe_o, fe_o, bi_o  output  1 each  parity error, framing error, break indication; qualified by push_o.
REQ-010 busy_o  output  1  high in every state except ST_IDLE.

Function
REQ-011 sin_i SHALL pass through a 2-flop synchronizer (reset value 1); all sampling SHALL use the synchronized value (sin_s).
REQ-012 All state and counter updates except push_o SHALL occur only on clk_i edges where baudout_i=1.
REQ-013 States SHALL be ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP and ST_BREAK; a 4-bit sample counter cnt and a 3-bit bit counter SHALL be kept.
REQ-014 ST_IDLE: on a tick with sin_s=0 -> ST_START with cnt=7.
REQ-015 ST_START: each tick cnt-1; at the tick with cnt=0, sample sin_s; if 1 (false start) -> ST_IDLE with no push; if 0 -> ST_DATA with cnt=15 and bitcnt=wls_i+4.
REQ-016 ST_DATA: at the tick with cnt=0, the sample SHALL be stored into bit (wls_i+4-bitcnt) of the data register, cnt=15, bitcnt-1; after the last bit (bitcnt=0) -> ST_PARITY if pen_i, else ST_STOP.
REQ-017 The data register SHALL be cleared to 0 on entry to ST_START.
REQ-018 ST_PARITY: at cnt=0, sample the parity bit, then -> ST_STOP with cnt=15.
REQ-019 Parity check: {stick,eps}=00 -> error if XOR(data, parity bit)=0 (odd); 01 -> error if XOR=1 (even); 10 -> error if parity bit!=1; 11 -> error if parity bit!=0.
REQ-020 pe_o SHALL be 0 whenever pen_i=0.
REQ-021 ST_STOP: at cnt=0, sample the first stop bit only; fe_o=~sample.
REQ-022 bi_o SHALL be 1 when the data bits, the parity bit (if enabled) and the stop bit were all 0.
REQ-023 push_o SHALL pulse in the clk_i cycle following the stop-bit sample tick, with d_o/pe_o/fe_o/bi_o registered and stable from that cycle until the next push.
REQ-024 After the stop sample, if sin_s=1 -> ST_IDLE; if sin_s=0 -> ST_BREAK, which holds until a tick with sin_s=1 and then -> ST_IDLE with no further push.
REQ-025 A new start bit SHALL be detectable on the first tick after returning to ST_IDLE (back-to-back characters, no gap required).
REQ-026 Changes to wls_i/pen_i/eps_i/stick_i while busy_o=1 are unsupported; configuration SHALL be sampled live.

Reset
REQ-027 On rst_ni=0, regardless of state (including mid-character), the block SHALL enter ST_IDLE with cnt=0, bitcnt=0, push_o=0, d_o=0, pe_o=0, fe_o=0, bi_o=0, busy_o=0 and synchronizer=1.
REQ-028 After reset release, any partially received character SHALL be discarded and never pushed.

Verification
REQ-029 8N1, baudout_i every cycle, frame 0x55 -> one push_o, d_o=0x55, pe/fe/bi=0.
REQ-030 7E1, send 0x41 with parity bit 1 -> d_o=0x41, pe_o=1; repeat with parity bit 0 -> pe_o=0.
REQ-031 Low glitch of 4 ticks on idle sin_i -> no push_o, return to ST_IDLE, busy_o=0.
REQ-032 5N1, sin_i held low for 3 frame times, then high -> exactly one push with d_o=0x00, fe_o=1, bi_o=1; busy_o held until sin_i returns high.
REQ-033 8N1, stop bit driven 0 with data 0xA3 -> d_o=0xA3, fe_o=1, bi_o=0.
REQ-034 Assert rst_ni=0 during data bit 3 of a frame -> all outputs at reset values, no push_o for that frame; the next full frame 0x3C -> d_o=0x3C.
